param_combo_lock: RTL and testbench

PARAM_COMBO_LOCK -- requirements
Module: param_combo_lock

---
 rtl/param_combo_lock.sv | 112 +++++++++++
 tb/tb_param_combo_lock.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_combo_lock.sv
// Parameterised combination lock with auto-relock, code change and an absorbing alarm.
// Outputs are decoded from the state register only, so there is no combinational path from inputs to outputs.
module param_combo_lock #(
    parameter int                 CODE_W      = 4,
    parameter int                 MAX_TRIES   = 3,
    parameter logic [CODE_W-1:0]  RESET_CODE  = CODE_W'(6),
    parameter int                 OPEN_CYCLES = 8
) (
    input  logic                           Clock,
    input  logic                           Resetn,
    input  logic                           Enter,
    input  logic                           Change,
    input  logic [CODE_W-1:0]              X,
    output logic                           Open,
    output logic                           New,
    output logic                           Alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0] Fails
);

    localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
    localparam int TIMER_W = $clog2(OPEN_CYCLES);

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        OPENED = 2'd1,
        CHANGE = 2'd2,
        ALARM  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CODE_W-1:0]   code_reg, code_next;
    logic [FAIL_W-1:0]   fails_reg, fails_next;
    logic [TIMER_W-1:0]  timer_reg, timer_next;
    logic                code_match;
    logic                last_try;

    // The entry is always judged against the code held before this edge.
    assign code_match = (X == code_reg);
    assign last_try   = ((int'(fails_reg) + 1) >= MAX_TRIES);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= LOCKED;
            code_reg  <= RESET_CODE;
            fails_reg <= '0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            fails_reg <= fails_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        fails_next = fails_reg;
        timer_next = timer_reg;

        case (state_reg)
            LOCKED: begin
                // Change has no effect here, so Enter+Change is just Enter.
                if (Enter) begin
                    if (code_match) begin
                        state_next = OPENED;
                        fails_next = '0;
                        timer_next = '0;
                    end else if (last_try) begin
                        state_next = ALARM;
                        fails_next = FAIL_W'(MAX_TRIES);
                    end else begin
                        fails_next = fails_reg + 1'b1;
                    end
                end
            end
            OPENED: begin
                timer_next = timer_reg + 1'b1;
                if (Change) begin
                    state_next = CHANGE;
                    timer_next = '0;
                end else if (Enter) begin
                    state_next = LOCKED;
                    timer_next = '0;
                end else if (timer_reg == TIMER_W'(OPEN_CYCLES - 1)) begin
                    state_next = LOCKED;
                    timer_next = '0;
                end
            end
            CHANGE: begin
                if (Enter) begin
                    code_next  = X;
                    state_next = LOCKED;
                end else if (Change) begin
                    state_next = LOCKED;
                end
            end
            ALARM: begin
                state_next = ALARM;
            end
            default: begin
                state_next = LOCKED;
            end
        endcase
    end

    assign Open  = (state_reg == OPENED);
    assign New   = (state_reg == CHANGE);
    assign Alarm = (state_reg == ALARM);
    assign Fails = fails_reg;

endmodule

// File: tb/tb_param_combo_lock.sv
// Directed bench for param_combo_lock: a default instance plus an 8-bit, single-try instance.
module tb_param_combo_lock;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enter, change;
    logic [3:0] x;
    logic       open_o, new_o, alarm_o;
    logic [1:0] fails_o;

    logic       enter_b, change_b;
    logic [7:0] x_b;
    logic       open_b, new_b, alarm_b;
    logic [0:0] fails_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_combo_lock dut (
        .Clock  (clk),
        .Resetn (resetn),
        .Enter  (enter),
        .Change (change),
        .X      (x),
        .Open   (open_o),
        .New    (new_o),
        .Alarm  (alarm_o),
        .Fails  (fails_o)
    );

    param_combo_lock #(
        .CODE_W      (8),
        .MAX_TRIES   (1),
        .RESET_CODE  (8'hA5),
        .OPEN_CYCLES (8)
    ) dut_b (
        .Clock  (clk),
        .Resetn (resetn),
        .Enter  (enter_b),
        .Change (change_b),
        .X      (x_b),
        .Open   (open_b),
        .New    (new_b),
        .Alarm  (alarm_b),
        .Fails  (fails_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the default instance's full output set in one go.
    task automatic chk_all(input string tag, input logic o, input logic n, input logic a, input logic [1:0] f);
        chk({tag, ".open"},  {15'd0, open_o},  {15'd0, o});
        chk({tag, ".new"},   {15'd0, new_o},   {15'd0, n});
        chk({tag, ".alarm"}, {15'd0, alarm_o}, {15'd0, a});
        chk({tag, ".fails"}, {14'd0, fails_o}, {14'd0, f});
        $display("step %-16s open=%0b new=%0b alarm=%0b fails=%0d", tag, open_o, new_o, alarm_o, fails_o);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input logic [3:0] v);
        x = v;
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 resetn = 1'b0;
        #2 chk_all("in_reset", 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        resetn = 1'b1;
        chk_all("after_reset", 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        resetn = 1'b0; enter = 1'b0; change = 1'b0; x = '0;
        enter_b = 1'b0; change_b = 1'b0; x_b = '0;
        #2 chk_all("reset_hold", 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        resetn = 1'b1;
        chk_all("reset_release", 1'b0, 1'b0, 1'b0, 2'd0);

        // Correct code opens for exactly eight idle cycles.
        submit(4'd6);
        chk_all("open_c0", 1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk({"open_hold"}, {15'd0, open_o}, 16'd1);
        end
        tick();
        chk_all("auto_relock", 1'b0, 1'b0, 1'b0, 2'd0);

        // Change ignored while locked; Enter+Change counts as a plain wrong entry.
        change = 1'b1;
        tick();
        chk_all("locked_change", 1'b0, 1'b0, 1'b0, 2'd0);
        x = 4'd3; enter = 1'b1;
        tick();
        enter = 1'b0; change = 1'b0;
        chk_all("lock_ent_chg", 1'b0, 1'b0, 1'b0, 2'd1);
        submit(4'd5);
        chk_all("wrong2", 1'b0, 1'b0, 1'b0, 2'd2);
        submit(4'd0);
        chk_all("wrong3_alarm", 1'b0, 1'b0, 1'b1, 2'd3);
        submit(4'd6);
        chk_all("alarm_absorb", 1'b0, 1'b0, 1'b1, 2'd3);
        change = 1'b1;
        tick();
        change = 1'b0;
        chk_all("alarm_change", 1'b0, 1'b0, 1'b1, 2'd3);
        pulse_reset();

        // Change the code to 9 and verify old code is rejected.
        submit(4'd6);
        chk_all("open_for_chg", 1'b1, 1'b0, 1'b0, 2'd0);
        change = 1'b1;
        tick();
        change = 1'b0;
        chk_all("change_mode", 1'b0, 1'b1, 1'b0, 2'd0);
        submit(4'd9);
        chk_all("code_written", 1'b0, 1'b0, 1'b0, 2'd0);
        submit(4'd6);
        chk_all("old_code_bad", 1'b0, 1'b0, 1'b0, 2'd1);
        submit(4'd9);
        chk_all("new_code_ok", 1'b1, 1'b0, 1'b0, 2'd0);
        submit(4'd0);
        chk_all("open_enter_lk", 1'b0, 1'b0, 1'b0, 2'd0);
        pulse_reset();

        // In OPEN, Change beats Enter; in CHANGE, Enter beats Change.
        submit(4'd6);
        x = 4'd1; enter = 1'b1; change = 1'b1;
        tick();
        enter = 1'b0; change = 1'b0;
        chk_all("open_prio", 1'b0, 1'b1, 1'b0, 2'd0);
        x = 4'hA; enter = 1'b1; change = 1'b1;
        tick();
        enter = 1'b0; change = 1'b0;
        chk_all("chg_prio", 1'b0, 1'b0, 1'b0, 2'd0);
        submit(4'hA);
        chk_all("code_A_ok", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse_reset();

        // CHANGE holds indefinitely, then Change alone aborts with code kept.
        submit(4'd6);
        change = 1'b1;
        tick();
        change = 1'b0;
        repeat (12) tick();
        chk_all("chg_hold", 1'b0, 1'b1, 1'b0, 2'd0);
        x = 4'hB; change = 1'b1;
        tick();
        change = 1'b0;
        chk_all("chg_abort", 1'b0, 1'b0, 1'b0, 2'd0);
        submit(4'd6);
        chk_all("code_still_6", 1'b1, 1'b0, 1'b0, 2'd0);
        submit(4'd0);

        // A correct entry clears the wrong-entry counter.
        submit(4'd1);
        submit(4'd2);
        chk_all("two_wrong", 1'b0, 1'b0, 1'b0, 2'd2);
        submit(4'd6);
        chk_all("clear_open", 1'b1, 1'b0, 1'b0, 2'd0);
        submit(4'd0);
        submit(4'd1);
        submit(4'd2);
        chk_all("no_alarm", 1'b0, 1'b0, 1'b0, 2'd2);
        pulse_reset();

        // Reset during CHANGE before the Enter edge discards the pending code.
        submit(4'd6);
        change = 1'b1;
        tick();
        change = 1'b0;
        x = 4'hC; enter = 1'b1;
        #2 resetn = 1'b0;
        #1 chk_all("rst_in_chg", 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        enter = 1'b0;
        resetn = 1'b1;
        chk_all("rst_chg_rel", 1'b0, 1'b0, 1'b0, 2'd0);
        submit(4'hC);
        chk_all("C_rejected", 1'b0, 1'b0, 1'b0, 2'd1);
        submit(4'd6);
        chk_all("six_restored", 1'b1, 1'b0, 1'b0, 2'd0);

        // 8-bit, single-try instance.
        x_b = 8'hA5; enter_b = 1'b1;
        tick();
        enter_b = 1'b0;
        chk("b.open", {15'd0, open_b}, 16'd1);
        $display("step b_open          open=%0b alarm=%0b fails=%0d", open_b, alarm_b, fails_b);
        enter_b = 1'b1;
        tick();
        enter_b = 1'b0;
        chk("b.relock", {15'd0, open_b}, 16'd0);
        x_b = 8'h5A; enter_b = 1'b1;
        tick();
        enter_b = 1'b0;
        chk("b.alarm", {15'd0, alarm_b}, 16'd1);
        chk("b.fails", {15'd0, fails_b}, 16'd1);
        chk("b.new", {15'd0, new_b}, 16'd0);
        $display("step b_wrong         open=%0b alarm=%0b fails=%0d", open_b, alarm_b, fails_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
